// File: rtl/eth_pkg.sv
// ---------------------------------------------------------------------------
// eth_pkg
// Shared definitions for the transmit-side frame buffer:
//   - default minimum / maximum accepted frame lengths (bytes)
//   - length word width used by the per-frame length queue
//   - write-side FSM state encoding
//   - saturating 16-bit increment helper used by the drop counter
// ---------------------------------------------------------------------------
package eth_pkg;

  localparam int unsigned MIN_LEN_DEFAULT = 60;
  localparam int unsigned MAX_LEN_DEFAULT = 1518;
  localparam int unsigned LEN_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DROP = 2'd2
  } wr_state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/len_fifo.sv
// ---------------------------------------------------------------------------
// len_fifo
// Synchronous show-ahead FIFO holding committed frame lengths.
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-low reset
//   i_push   - write i_din (ignored when full unless a pop happens too)
//   i_din    - length word to store
//   i_pop    - remove head entry (ignored when empty)
//   o_head   - current head entry (valid only when !o_empty)
//   o_full   - DEPTH entries stored
//   o_empty  - no entries stored
// ---------------------------------------------------------------------------
module len_fifo
  import eth_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = LEN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] C_DEPTH   = (AW + 1)'(DEPTH);

  // Pointers carry one extra bit so full and empty are distinguishable.
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic w_pop;
  logic w_push;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = ((r_wr_ptr - r_rd_ptr) == C_DEPTH);
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  assign w_pop  = i_pop && !o_empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign w_push = i_push && (!o_full || w_pop);

  // Storage array write port; contents need no reset because pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[AW-1:0]] <= i_din;
    end
  end

  // Pointer update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= {(AW + 1){1'b0}};
      r_rd_ptr <= {(AW + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/tx_frame_buffer.sv
// ---------------------------------------------------------------------------
// tx_frame_buffer
// Store-and-forward frame buffer in front of the transmit controller. Bytes
// of a frame are written speculatively and only become readable once the
// frame's last beat is accepted; bad, runt, oversize or overflowing frames
// are rolled back by restoring the write pointer to the last commit point.
// Ports:
//   clk, rst        - clock; synchronous active-low reset
//   in_data/valid   - write byte stream, no backpressure
//   in_last         - marks final byte of a frame
//   in_error        - marks the frame bad; frame is dropped
//   tx_data         - registered read byte
//   nextByte        - level read request, one byte per cycle
//   frm_len         - head frame length, 0 when queue empty
//   nextLen         - rising edge pops the length queue
//   empty_buff      - no committed bytes available
//   empty_len_buff  - length queue empty
//   drop_cnt        - saturating count of dropped frames
//   drop_pulse      - one-cycle pulse per dropped frame
// ---------------------------------------------------------------------------
module tx_frame_buffer
  import eth_pkg::*;
#(
  parameter int unsigned DATA_DEPTH = 2048,
  parameter int unsigned LEN_DEPTH  = 16,
  parameter int unsigned MIN_LEN    = MIN_LEN_DEFAULT,
  parameter int unsigned MAX_LEN    = MAX_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic        in_error,
  output logic [7:0]  tx_data,
  input  logic        nextByte,
  output logic [15:0] frm_len,
  input  logic        nextLen,
  output logic        empty_buff,
  output logic        empty_len_buff,
  output logic [15:0] drop_cnt,
  output logic        drop_pulse
);

  localparam int unsigned AW = $clog2(DATA_DEPTH);
  localparam logic [AW:0] C_PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] C_DEPTH   = (AW + 1)'(DATA_DEPTH);
  localparam logic [16:0] C_MIN_LEN = 17'(MIN_LEN);
  localparam logic [16:0] C_MAX_LEN = 17'(MAX_LEN);

  // Write side state
  wr_state_e   r_state;
  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_commit_ptr;
  logic [15:0] r_cur_len;
  logic [15:0] r_drop_cnt;
  logic        r_drop_pulse;

  // Read side state
  logic [AW:0] r_rd_ptr;
  logic [7:0]  r_tx_data;
  logic        r_next_len_q;

  logic [7:0]  r_mem [DATA_DEPTH];

  logic [16:0] w_len_next;
  logic        w_store_full;
  logic        w_accept;
  logic        w_drop_trig;
  logic        w_wr_en;
  logic        w_commit;
  logic        w_rd_en;
  logic        w_len_pop;
  logic        w_len_full;
  logic        w_len_empty;
  logic [15:0] w_len_head;
  logic        w_empty_buff;

  // Length including the beat currently presented; 17 bits so the
  // oversize compare cannot wrap.
  assign w_len_next   = {1'b0, r_cur_len} + 17'd1;
  // Occupancy counts uncommitted bytes too: a frame in flight consumes space.
  assign w_store_full = ((r_wr_ptr - r_rd_ptr) == C_DEPTH);
  assign w_accept     = in_valid && (r_state != ST_DROP);
  assign w_empty_buff = (r_commit_ptr == r_rd_ptr);

  // Drop decision for the beat being accepted this cycle.
  always_comb begin
    w_drop_trig = 1'b0;
    if (w_accept) begin
      if (in_error || w_store_full || (w_len_next > C_MAX_LEN)) begin
        w_drop_trig = 1'b1;
      end else if (in_last && ((w_len_next < C_MIN_LEN) || w_len_full)) begin
        w_drop_trig = 1'b1;
      end else begin
        w_drop_trig = 1'b0;
      end
    end else begin
      w_drop_trig = 1'b0;
    end
  end

  assign w_wr_en   = w_accept && !w_drop_trig;
  assign w_commit  = w_wr_en && in_last;
  assign w_rd_en   = nextByte && !w_empty_buff;
  assign w_len_pop = nextLen && !r_next_len_q && !w_len_empty;

  // Write FSM: speculative writes, commit on last beat, rollback on drop.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_wr_ptr     <= {(AW + 1){1'b0}};
      r_commit_ptr <= {(AW + 1){1'b0}};
      r_cur_len    <= 16'd0;
      r_drop_cnt   <= 16'd0;
      r_drop_pulse <= 1'b0;
    end else begin
      r_drop_pulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_RECV: begin
          if (in_valid) begin
            if (w_drop_trig) begin
              r_wr_ptr     <= r_commit_ptr;
              r_cur_len    <= 16'd0;
              r_drop_pulse <= 1'b1;
              r_drop_cnt   <= sat_inc16(r_drop_cnt);
              // A trigger on the last beat already ends the frame.
              r_state      <= in_last ? ST_IDLE : ST_DROP;
            end else if (in_last) begin
              r_wr_ptr     <= r_wr_ptr + C_PTR_ONE;
              r_commit_ptr <= r_wr_ptr + C_PTR_ONE;
              r_cur_len    <= 16'd0;
              r_state      <= ST_IDLE;
            end else begin
              r_wr_ptr     <= r_wr_ptr + C_PTR_ONE;
              r_cur_len    <= w_len_next[15:0];
              r_state      <= ST_RECV;
            end
          end else begin
            r_state <= r_state;
          end
        end
        ST_DROP: begin
          if (in_valid && in_last) begin
            r_state <= ST_IDLE;
          end else begin
            r_state <= ST_DROP;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Byte storage write port; rolled-back bytes are simply overwritten later.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // Read port: registered byte out, pointer advances only over committed data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rd_ptr  <= {(AW + 1){1'b0}};
      r_tx_data <= 8'd0;
    end else if (w_rd_en) begin
      r_rd_ptr  <= r_rd_ptr + C_PTR_ONE;
      r_tx_data <= r_mem[r_rd_ptr[AW-1:0]];
    end else begin
      r_rd_ptr  <= r_rd_ptr;
      r_tx_data <= r_tx_data;
    end
  end

  // Previous nextLen level for rising-edge pop detection.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_next_len_q <= 1'b0;
    end else begin
      r_next_len_q <= nextLen;
    end
  end

  len_fifo #(
    .DEPTH (LEN_DEPTH),
    .WIDTH (LEN_W)
  ) u_len_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_commit),
    .i_din   (w_len_next[15:0]),
    .i_pop   (w_len_pop),
    .o_head  (w_len_head),
    .o_full  (w_len_full),
    .o_empty (w_len_empty)
  );

  assign tx_data        = r_tx_data;
  assign frm_len        = w_len_empty ? 16'd0 : w_len_head;
  assign empty_buff     = w_empty_buff;
  assign empty_len_buff = w_len_empty;
  assign drop_cnt       = r_drop_cnt;
  assign drop_pulse     = r_drop_pulse;

endmodule

// File: tb/tb_tx_frame_buffer.sv
// ---------------------------------------------------------------------------
// tb_tx_frame_buffer
// Self-checking bench: a queue-based reference model of committed bytes,
// the pending frame and the length queue is updated every clock from the
// driven inputs; a negedge process compares every output against it.
// Directed scenarios add literal expectations; a random phase follows.
// ---------------------------------------------------------------------------
module tb_tx_frame_buffer;

  localparam int DD   = 128;
  localparam int LD   = 16;
  localparam int MINL = 60;
  localparam int MAXL = 120;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid, in_last, in_error;
  logic [7:0]  tx_data;
  logic        nextByte;
  logic [15:0] frm_len;
  logic        nextLen;
  logic        empty_buff, empty_len_buff;
  logic [15:0] drop_cnt;
  logic        drop_pulse;

  always #5 clk = ~clk;

  tx_frame_buffer #(
    .DATA_DEPTH (DD),
    .LEN_DEPTH  (LD),
    .MIN_LEN    (MINL),
    .MAX_LEN    (MAXL)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_error       (in_error),
    .tx_data        (tx_data),
    .nextByte       (nextByte),
    .frm_len        (frm_len),
    .nextLen        (nextLen),
    .empty_buff     (empty_buff),
    .empty_len_buff (empty_len_buff),
    .drop_cnt       (drop_cnt),
    .drop_pulse     (drop_pulse)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en  = 1'b0;
  bit rd_rand = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  byte unsigned bq[$];    // committed, unread bytes
  byte unsigned pend[$];  // bytes of the frame being received
  int           lq[$];    // committed frame lengths
  bit           m_drop;
  int           m_cnt;
  bit           m_pulse;
  logic [7:0]   m_tx;
  bit           m_nlq;
  int           m_occ, m_nl;
  bit           m_trig, m_do_rd, m_do_pop;

  always @(posedge clk) begin
    if (!rst) begin
      bq.delete(); pend.delete(); lq.delete();
      m_drop = 0; m_cnt = 0; m_pulse = 0; m_tx = 8'd0; m_nlq = 0;
    end else begin
      m_do_rd  = nextByte && (bq.size() > 0);
      m_do_pop = nextLen && !m_nlq && (lq.size() > 0);
      m_occ    = bq.size() + pend.size();
      m_pulse  = 0;
      if (in_valid) begin
        if (m_drop) begin
          if (in_last) m_drop = 0;
        end else begin
          m_nl   = pend.size() + 1;
          m_trig = in_error || (m_occ == DD) || (m_nl > MAXL) ||
                   (in_last && ((m_nl < MINL) || (lq.size() == LD)));
          if (m_trig) begin
            pend.delete();
            if (m_cnt < 65535) m_cnt++;
            m_pulse = 1;
            m_drop  = !in_last;
          end else begin
            pend.push_back(in_data);
            if (in_last) begin
              foreach (pend[k]) bq.push_back(pend[k]);
              lq.push_back(m_nl);
              pend.delete();
            end
          end
        end
      end
      if (m_do_rd) m_tx = bq.pop_front();
      if (m_do_pop) void'(lq.pop_front());
      m_nlq = nextLen;
    end
  end

  // Compare every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx_data", tx_data, m_tx);
      chk("frm_len", frm_len, (lq.size() != 0) ? lq[0] : 0);
      chk("empty_buff", empty_buff, bq.size() == 0);
      chk("empty_len_buff", empty_len_buff, lq.size() == 0);
      chk("drop_cnt", drop_cnt, m_cnt);
      chk("drop_pulse", drop_pulse, m_pulse);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_error = 1'b0;
    if (rd_rand) begin
      nextByte = 1'($urandom_range(0, 1));
      nextLen  = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic send_frame(input int len, input int err_at, input int base,
                            input bit rnd, input bit gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) tick();
      in_valid = 1'b1;
      in_data  = rnd ? 8'($urandom_range(0, 255)) : 8'(base + i);
      in_last  = (i == len - 1);
      in_error = (i == err_at);
      tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; nextByte = 1'b0; nextLen = 1'b0;
    in_valid = 1'b0; in_last = 1'b0; in_error = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic read_bytes(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      nextByte = 1'b1;
      tick();
      chk("rd_byte", tx_data, 8'(base + i));
    end
    nextByte = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_tx_data", tx_data, 0);
    chk("rst_frm_len", frm_len, 0);
    chk("rst_empty_buff", empty_buff, 1);
    chk("rst_empty_len", empty_len_buff, 1);
    chk("rst_drop_cnt", drop_cnt, 0);
    chk("rst_drop_pulse", drop_pulse, 0);
  endtask

  initial begin
    in_data = 8'd0;
    do_reset();
    chk_en = 1'b1;
    chk_reset_vals();

    // Single 64-byte frame, full readback.
    send_frame(64, -1, 0, 0, 0);
    chk("s1_frm_len", frm_len, 64);
    chk("s1_empty_len", empty_len_buff, 0);
    nextLen = 1'b1; tick(); nextLen = 1'b0; tick();
    chk("s1_frm_len_pop", frm_len, 0);
    read_bytes(64, 0);
    chk("s1_empty_buff", empty_buff, 1);

    // Runt then minimum-length frame.
    do_reset();
    send_frame(40, -1, 'h80, 0, 0);
    chk("s2_pulse", drop_pulse, 1);
    chk("s2_cnt", drop_cnt, 1);
    tick();
    chk("s2_pulse_low", drop_pulse, 0);
    send_frame(60, -1, 'h10, 0, 0);
    chk("s2_frm_len", frm_len, 60);
    chk("s2_cnt2", drop_cnt, 1);
    read_bytes(60, 'h10);
    nextLen = 1'b1; tick(); nextLen = 1'b0;
    chk("s2_empty_len", empty_len_buff, 1);

    // Error mid-frame: rolled back, then next frame accepted.
    do_reset();
    send_frame(100, 50, 0, 0, 0);
    chk("s3_empty_buff", empty_buff, 1);
    chk("s3_cnt", drop_cnt, 1);
    send_frame(60, -1, 'h40, 0, 0);
    chk("s3_frm_len", frm_len, 60);
    chk("s3_cnt2", drop_cnt, 1);

    // Storage overflow on second frame; first intact.
    do_reset();
    send_frame(100, -1, 0, 0, 0);
    send_frame(60, -1, 'hA0, 0, 0);
    chk("s4_cnt", drop_cnt, 1);
    chk("s4_frm_len", frm_len, 100);
    read_bytes(100, 0);
    chk("s4_empty_buff", empty_buff, 1);

    // Length boundaries: 59 dropped, MAX accepted, MAX+1 dropped.
    do_reset();
    send_frame(59, -1, 0, 0, 0);
    chk("s5_cnt59", drop_cnt, 1);
    send_frame(120, -1, 3, 0, 0);
    chk("s5_frm_len120", frm_len, 120);
    read_bytes(120, 3);
    nextLen = 1'b1; tick(); nextLen = 1'b0;
    send_frame(121, -1, 0, 0, 0);
    chk("s5_cnt121", drop_cnt, 2);
    chk("s5_empty_len", empty_len_buff, 1);

    // Length queue full: 17th frame dropped; held nextLen pops once.
    do_reset();
    nextByte = 1'b1;
    for (int f = 0; f < 17; f++) send_frame(60, -1, f * 3, 0, 0);
    chk("s6_cnt", drop_cnt, 1);
    chk("s6_frm_len", frm_len, 60);
    nextLen = 1'b1;
    repeat (10) tick();
    nextLen = 1'b0;
    tick();
    for (int k = 1; k <= 15; k++) begin
      nextLen = 1'b1; tick(); nextLen = 1'b0; tick();
      if (k == 14) chk("s6_len_left1", empty_len_buff, 0);
    end
    chk("s6_len_empty", empty_len_buff, 1);
    nextByte = 1'b0;

    // Reset mid-frame after one committed frame.
    do_reset();
    send_frame(60, -1, 0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      in_valid = 1'b1; in_data = 8'(i); tick();
    end
    rst = 1'b0; tick();
    chk_reset_vals();
    rst = 1'b1; tick();

    // Random traffic with random read and pop activity.
    do_reset();
    rd_rand = 1'b1;
    for (int n = 0; n < 150; n++) begin
      int len, err;
      len = int'($urandom_range(50, 125));
      err = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      send_frame(len, err, 0, 1, 1);
    end
    rd_rand = 1'b0;
    nextByte = 1'b1;
    for (int k = 0; k < 150; k++) begin
      nextLen = 1'b1; tick(); nextLen = 1'b0; tick();
    end
    nextByte = 1'b0;
    tick();
    chk("end_empty_buff", empty_buff, 1);
    chk("end_empty_len", empty_len_buff, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
